// File: rtl/pipelined_alu_if.sv
// ============================================================================
// Module   : pipelined_alu_if
// Brief    : Issue/writeback handshake bundle for the pipelined ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipelined_alu_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero_flag;
    logic             neg_flag;
    logic             carry_flag;
    logic             ovf_flag;
    logic             err_flag;

    // Issue stage + writeback consumer side
    modport master (
        output in_valid,
        output a,
        output b,
        output op,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  zero_flag,
        input  neg_flag,
        input  carry_flag,
        input  ovf_flag,
        input  err_flag
    );

    // ALU side
    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  op,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output zero_flag,
        output neg_flag,
        output carry_flag,
        output ovf_flag,
        output err_flag
    );
endinterface

`default_nettype wire

// File: rtl/pipelined_alu.sv
// ============================================================================
// Module   : pipelined_alu
// Brief    : WIDTH-bit registered ALU with valid/ready handshakes, status
//            flags and an iterative shift-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_alu #(
    parameter int WIDTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    pipelined_alu_if.slave     bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] c_OP_ADD  = 4'h0;
    localparam logic [3:0] c_OP_SUB  = 4'h1;
    localparam logic [3:0] c_OP_AND  = 4'h2;
    localparam logic [3:0] c_OP_OR   = 4'h3;
    localparam logic [3:0] c_OP_XOR  = 4'h4;
    localparam logic [3:0] c_OP_NOT  = 4'h5;
    localparam logic [3:0] c_OP_SLL  = 4'h6;
    localparam logic [3:0] c_OP_SRL  = 4'h7;
    localparam logic [3:0] c_OP_SRA  = 4'h8;
    localparam logic [3:0] c_OP_ROL  = 4'h9;
    localparam logic [3:0] c_OP_ROR  = 4'hA;
    localparam logic [3:0] c_OP_SLT  = 4'hB;
    localparam logic [3:0] c_OP_SLTU = 4'hC;
    localparam logic [3:0] c_OP_MUL  = 4'hD;

    localparam logic [SHW-1:0] c_CNT_LAST = SHW'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_neg;
    logic               r_carry;
    logic               r_ovf;
    logic               r_err;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_acc;
    logic [SHW-1:0]     r_cnt;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_pop;
    logic               w_is_mul;
    logic [SHW-1:0]     w_sh;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_rol2;
    logic [2*WIDTH-1:0] w_ror2;
    logic [WIDTH-1:0]   w_res;
    logic               w_carry;
    logic               w_ovf;
    logic               w_err;
    logic [WIDTH-1:0]   w_acc_next;

    // Handshake; in_ready is forced low while reset is asserted
    assign w_in_ready = rst_n && (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_pop      = r_out_valid && bus.out_ready;
    assign w_is_mul   = (bus.op == c_OP_MUL);

    assign w_sh   = bus.b[SHW-1:0];
    assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_diff = {1'b0, bus.a} - {1'b0, bus.b};
    // Rotates via a doubled operand keep every shift within range
    assign w_rol2 = {bus.a, bus.a} << w_sh;
    assign w_ror2 = {bus.a, bus.a} >> w_sh;

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_err   = 1'b0;
        case (bus.op)
            c_OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                          (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
                w_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                          (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            c_OP_AND:  w_res = bus.a & bus.b;
            c_OP_OR:   w_res = bus.a | bus.b;
            c_OP_XOR:  w_res = bus.a ^ bus.b;
            c_OP_NOT:  w_res = ~bus.a;
            c_OP_SLL:  w_res = bus.a << w_sh;
            c_OP_SRL:  w_res = bus.a >> w_sh;
            c_OP_SRA:  w_res = WIDTH'($signed(bus.a) >>> w_sh);
            c_OP_ROL:  w_res = w_rol2[2*WIDTH-1:WIDTH];
            c_OP_ROR:  w_res = w_ror2[WIDTH-1:0];
            c_OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            c_OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            c_OP_MUL:  w_res = '0;
            default:   w_err = 1'b1;
        endcase
    end

    assign w_acc_next = r_b_sh[0] ? (r_acc + r_a_sh) : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_is_mul) begin
                        // Output register is free or popping on this edge
                        r_a_sh      <= bus.a;
                        r_b_sh      <= bus.b;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b0;
                        r_state     <= S_BUSY;
                    end else if (w_accept) begin
                        r_result    <= w_res;
                        r_zero      <= (w_res == '0);
                        r_neg       <= w_res[WIDTH-1];
                        r_carry     <= w_carry;
                        r_ovf       <= w_ovf;
                        r_err       <= w_err;
                        r_out_valid <= 1'b1;
                    end else if (w_pop) begin
                        r_out_valid <= 1'b0;
                    end
                end
                S_BUSY: begin
                    r_acc  <= w_acc_next;
                    r_a_sh <= r_a_sh << 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_result    <= w_acc_next;
                        r_zero      <= (w_acc_next == '0);
                        r_neg       <= w_acc_next[WIDTH-1];
                        r_carry     <= 1'b0;
                        r_ovf       <= 1'b0;
                        r_err       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_IDLE;
                    end else if (w_pop) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.result     = r_result;
    assign bus.zero_flag  = r_zero;
    assign bus.neg_flag   = r_neg;
    assign bus.carry_flag = r_carry;
    assign bus.ovf_flag   = r_ovf;
    assign bus.err_flag   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_alu.sv
// ============================================================================
// Module   : tb_pipelined_alu
// Brief    : Directed self-checking bench for pipelined_alu (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_alu;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    pipelined_alu_if #(.WIDTH(WIDTH)) bus ();

    pipelined_alu #(.WIDTH(WIDTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Flags packed as {err, ovf, carry, neg, zero}
    function automatic logic [4:0] flags();
        return {bus.err_flag, bus.ovf_flag, bus.carry_flag, bus.neg_flag, bus.zero_flag};
    endfunction

    task automatic expect_out(input string tag, input logic [7:0] res, input logic [4:0] fl);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_result"}, 32'(bus.result), 32'(res));
        check({tag, "_flags"}, 32'(flags()), 32'(fl));
    endtask

    // Present one transaction for one edge, then sample #1 after it
    task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    logic [7:0] xa [4] = '{8'h12, 8'hFF, 8'hAA, 8'h3C};
    logic [7:0] xb [4] = '{8'h34, 8'h0F, 8'h55, 8'h3C};
    logic [7:0] xr [4] = '{8'h26, 8'hF0, 8'hFF, 8'h00};

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.op        = 4'h0;
        bus.a         = '0;
        bus.b         = '0;

        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_flags", 32'(flags()), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        do_op(4'h0, 8'hFF, 8'h01);
        expect_out("add_ff_01", 8'h00, 5'b00101);
        do_op(4'h1, 8'h80, 8'h01);
        expect_out("sub_80_01", 8'h7F, 5'b01000);
        do_op(4'h1, 8'h01, 8'h02);
        expect_out("sub_01_02", 8'hFF, 5'b00110);

        // Multiply: ready low for seven edges, result on the eighth
        do_op(4'hD, 8'h0F, 8'h11);
        check("mul_e0_in_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 1; i < WIDTH; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("mul_e%0d_in_ready", i), 32'(bus.in_ready), 32'd0);
            check($sformatf("mul_e%0d_out_valid", i), 32'(bus.out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        expect_out("mul_0f_11", 8'hFF, 5'b00010);
        check("mul_done_in_ready", 32'(bus.in_ready), 32'd1);

        do_op(4'h8, 8'h90, 8'h03);
        expect_out("sra_90_3", 8'hF2, 5'b00010);
        do_op(4'hA, 8'h81, 8'h01);
        expect_out("ror_81_1", 8'hC0, 5'b00010);
        do_op(4'h9, 8'h81, 8'h01);
        expect_out("rol_81_1", 8'h03, 5'b00000);
        do_op(4'hB, 8'hFE, 8'h01);
        expect_out("slt_fe_01", 8'h01, 5'b00000);
        do_op(4'hC, 8'hFE, 8'h01);
        expect_out("sltu_fe_01", 8'h00, 5'b00001);

        // Back-to-back XOR stream
        bus.in_valid = 1'b1;
        bus.op       = 4'h4;
        for (int i = 0; i < 4; i++) begin
            bus.a = xa[i];
            bus.b = xb[i];
            @(posedge clk);
            #1;
            check($sformatf("xor%0d_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("xor%0d_result", i), 32'(bus.result), 32'(xr[i]));
        end

        // Backpressure with an ADD pending at the input
        bus.out_ready = 1'b0;
        bus.op        = 4'h0;
        bus.a         = 8'h10;
        bus.b         = 8'h20;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp%0d_in_ready", i), 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("bp%0d_result", i), 32'(bus.result), 32'h00);
            check($sformatf("bp%0d_valid", i), 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        expect_out("pop_accept_add", 8'h30, 5'b00000);

        do_op(4'hE, 8'h55, 8'h00);
        expect_out("illegal_e", 8'h00, 5'b10001);
        do_op(4'h3, 8'h0F, 8'hF0);
        expect_out("or_after_err", 8'hFF, 5'b00010);

        // Reset in the middle of a multiply
        do_op(4'hD, 8'h03, 8'h05);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_result", 32'(bus.result), 32'd0);
        check("midrst_flags", 32'(flags()), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_rel_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < WIDTH; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("midrst_idle%0d_valid", i), 32'(bus.out_valid), 32'd0);
        end
        do_op(4'h0, 8'h02, 8'h03);
        expect_out("add_02_03", 8'h05, 5'b00000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
